// File: rtl/pcie_rx_pkg.sv
// Shared constants, per-symbol descrambler state and the LFSR byte step
// used by the Gen1/Gen2 receive descrambler.
package pcie_rx_pkg;

  localparam logic [7:0]  COM         = 8'hBC;
  localparam logic [7:0]  SKP         = 8'h1C;
  localparam logic [7:0]  FTS         = 8'h3C;
  localparam logic [7:0]  IDL         = 8'h7C;
  localparam logic [15:0] LFSR_SEED   = 16'hFFFF;
  localparam logic [3:0]  TS_BODY_LEN = 4'd15;

  typedef struct packed {
    logic [15:0] lfsr;
    logic [3:0]  bypass_cnt;
    logic        after_com;
    logic        locked;
  } desc_state_t;

  // Returns {next_lfsr, scramble_byte}; bit j is lfsr[15] taken before the j-th shift.
  function automatic logic [23:0] lfsr_step8(input logic [15:0] s);
    logic [15:0] l;
    logic [7:0]  m;
    l = s;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      m[j] = l[15];
      l    = {l[14:0], 1'b0} ^ ({16{l[15]}} & 16'h0039);
    end
    return {l, m};
  endfunction

endpackage

// File: rtl/rx_descramble_symbol.sv
// One symbol slot of the descrambler: applies framing, TS bypass and XOR rules
// to a single symbol and hands the updated state to the next slot.
module rx_descramble_symbol
  import pcie_rx_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  desc_state_t i_state,
  input  logic [7:0]  i_sym,
  input  logic        i_k,
  input  logic        i_en,
  input  logic        i_xor_en,
  output desc_state_t o_state,
  output logic [7:0]  o_sym
);

  logic [23:0] w_step;
  logic        w_is_com;
  logic        w_is_skp;
  logic        w_no_ts;
  logic        w_bypass;

  assign w_step   = lfsr_step8(i_state.lfsr);
  assign w_is_com = i_k && (i_sym == COM);
  assign w_is_skp = i_k && (i_sym == SKP);
  assign w_no_ts  = i_k && (i_sym == SKP || i_sym == FTS || i_sym == IDL);

  always_comb begin
    o_state  = i_state;
    o_sym    = i_sym;
    w_bypass = 1'b0;
    if (i_en) begin
      if (w_is_com) begin
        o_state.lfsr       = SEED;
        o_state.locked     = 1'b1;
        o_state.after_com  = 1'b1;
        o_state.bypass_cnt = 4'd0;
      end else begin
        o_state.after_com = 1'b0;
        if (!w_is_skp)
          o_state.lfsr = w_step[23:8];
        // The opening symbol of a TS body is itself the first bypassed symbol.
        if (i_state.after_com && !w_no_ts) begin
          w_bypass           = 1'b1;
          o_state.bypass_cnt = TS_BODY_LEN - 4'd1;
        end else if (i_state.bypass_cnt != 4'd0) begin
          w_bypass           = 1'b1;
          o_state.bypass_cnt = i_state.bypass_cnt - 4'd1;
        end
        if (!i_k && i_state.locked && i_xor_en && !w_bypass)
          o_sym = i_sym ^ w_step[7:0];
      end
    end
  end

endmodule

// File: rtl/rx_descrambler.sv
// Per-lane Gen1/Gen2 receive descrambler: a chain of symbol slots processed
// in index order each cycle, with one registered output stage.
module rx_descrambler
  import pcie_rx_pkg::desc_state_t;
#(
  parameter int          MAXPIPEWIDTH = 32,
  parameter logic [15:0] LFSR_SEED    = pcie_rx_pkg::LFSR_SEED
) (
  input  logic                      pclk,
  input  logic                      reset,
  input  logic [2:0]                gen,
  input  logic [5:0]                pipewidth,
  input  logic                      turnOff,
  input  logic [MAXPIPEWIDTH-1:0]   RxData,
  input  logic [MAXPIPEWIDTH/8-1:0] RxDataK,
  input  logic                      RxValid,
  output logic [MAXPIPEWIDTH-1:0]   DataOut,
  output logic [MAXPIPEWIDTH/8-1:0] DataKOut,
  output logic                      DataValidOut,
  output logic                      locked
);

  localparam int NSYM = MAXPIPEWIDTH / 8;
  localparam desc_state_t RST_STATE = '{lfsr: LFSR_SEED, bypass_cnt: 4'd0,
                                        after_com: 1'b0, locked: 1'b0};

  desc_state_t                r_state;
  logic [2:0]                 r_gen;
  desc_state_t                w_chain [NSYM+1];
  logic [NSYM-1:0][7:0]       w_sym_out;
  logic [NSYM-1:0][7:0]       w_data;
  logic [NSYM-1:0]            w_k;
  logic [NSYM-1:0]            w_en;
  logic [2:0]                 w_nact;
  logic                       w_gen_chg;
  logic                       w_xor_en;

  assign w_gen_chg  = (gen != r_gen);
  assign w_xor_en   = !turnOff && (gen == 3'd1 || gen == 3'd2);
  assign w_chain[0] = r_state;
  assign locked     = r_state.locked;

  always_comb begin
    w_nact = 3'd1;
    case (pipewidth)
      6'd16:   w_nact = 3'd2;
      6'd32:   w_nact = 3'd4;
      default: w_nact = 3'd1;
    endcase
  end

  for (genvar g = 0; g < NSYM; g++) begin : g_sym
    assign w_en[g] = RxValid && !w_gen_chg && (3'(g) < w_nact);

    rx_descramble_symbol #(.SEED(LFSR_SEED)) u_sym (
      .i_state  (w_chain[g]),
      .i_sym    (RxData[8*g +: 8]),
      .i_k      (RxDataK[g]),
      .i_en     (w_en[g]),
      .i_xor_en (w_xor_en),
      .o_state  (w_chain[g+1]),
      .o_sym    (w_sym_out[g])
    );

    // Slots beyond the active width are zeroed rather than passed through.
    assign w_data[g] = (3'(g) < w_nact) ? w_sym_out[g] : 8'h00;
    assign w_k[g]    = (3'(g) < w_nact) && RxDataK[g];
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state      <= RST_STATE;
      r_gen        <= gen;
      DataOut      <= '0;
      DataKOut     <= '0;
      DataValidOut <= 1'b0;
    end else begin
      r_gen        <= gen;
      DataValidOut <= RxValid;
      r_state      <= w_gen_chg ? RST_STATE : w_chain[NSYM];
      if (RxValid) begin
        DataOut  <= w_data;
        DataKOut <= w_k;
      end
    end
  end

endmodule

// File: tb/tb_rx_descrambler.sv
// Scoreboard bench for rx_descrambler: a keystream-position reference model
// predicts each valid output word; a monitor pops and compares.
module tb_rx_descrambler;

  logic        pclk = 1'b0;
  logic        reset;
  logic [2:0]  gen;
  logic [5:0]  pipewidth;
  logic        turnOff;
  logic [31:0] RxData;
  logic [3:0]  RxDataK;
  logic        RxValid;
  logic [31:0] DataOut;
  logic [3:0]  DataKOut;
  logic        DataValidOut;
  logic        locked;

  always #5 pclk = ~pclk;

  rx_descrambler dut (
    .pclk(pclk), .reset(reset), .gen(gen), .pipewidth(pipewidth),
    .turnOff(turnOff), .RxData(RxData), .RxDataK(RxDataK), .RxValid(RxValid),
    .DataOut(DataOut), .DataKOut(DataKOut), .DataValidOut(DataValidOut),
    .locked(locked)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    bit          lk;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Reference model: position in the keystream since the last seed, not LFSR state.
  byte unsigned ks[65535];
  int           m_pos, m_rem;
  bit           m_after, m_locked;
  logic [2:0]   m_gen;
  logic [31:0]  m_last;

  task automatic build_keystream();
    int l = 'hFFFF;
    for (int p = 0; p < 65535; p++) begin
      int b = 0;
      for (int j = 0; j < 8; j++) begin
        b = b | (((l >> 15) & 1) << j);
        l = l << 1;
        if ((l & 'h10000) != 0) l = l ^ 'h10039;
      end
      ks[p] = byte'(b);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_rem = 0; m_after = 0; m_locked = 0; m_last = '0;
    m_gen = gen;
    sb.delete();
  endtask

  task automatic model_cycle(input logic [31:0] d, input logic [3:0] k, input bit v);
    int   n;
    bit   chg;
    exp_t e;
    n   = (pipewidth == 6'd16) ? 2 : (pipewidth == 6'd32) ? 4 : 1;
    chg = (gen != m_gen);
    m_gen = gen;
    e.d = '0; e.k = '0;
    for (int i = 0; i < n; i++) begin
      logic [7:0] sym, out;
      bit kk, byp;
      sym = d[8*i +: 8]; kk = k[i]; out = sym;
      if (v && !chg) begin
        if (kk && sym == 8'hBC) begin
          m_pos = 0; m_locked = 1; m_after = 1; m_rem = 0;
        end else begin
          if (m_after && !(kk && (sym == 8'h1C || sym == 8'h3C || sym == 8'h7C)))
            m_rem = 15;
          m_after = 0;
          byp = (m_rem > 0);
          if (m_rem > 0) m_rem--;
          if (!kk && m_locked && !turnOff && (gen == 3'd1 || gen == 3'd2) && !byp)
            out = sym ^ 8'(ks[m_pos]);
          if (!(kk && sym == 8'h1C)) m_pos = (m_pos + 1) % 65535;
        end
      end
      e.d[8*i +: 8] = out;
      e.k[i] = kk;
    end
    if (chg) begin m_pos = 0; m_locked = 0; m_rem = 0; m_after = 0; end
    e.lk = m_locked;
    if (v) begin
      sb.push_back(e);
      m_last = e.d;
    end
  endtask

  task automatic cyc(input logic [31:0] d, input logic [3:0] k, input bit v);
    RxData = d; RxDataK = k; RxValid = v;
    model_cycle(d, k, v);
    @(posedge pclk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; RxValid = 1'b1; RxData = $urandom; RxDataK = 4'h0;
    @(posedge pclk); #1;
    reset = 1'b0; RxValid = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge pclk);
      if (DataValidOut === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: got data %h with empty scoreboard", DataOut);
        end else begin
          e = sb.pop_front();
          if (DataOut !== e.d || DataKOut !== e.k || locked !== e.lk) begin
            n_bad++;
            $display("FAIL word: got d=%h k=%h lk=%b expected d=%h k=%h lk=%b",
                     DataOut, DataKOut, locked, e.d, e.k, e.lk);
          end
        end
      end
    end
  end

  function automatic logic [7:0] rnd_sym(output bit k);
    int r = $urandom_range(0, 99);
    k = 1'b1;
    if (r < 8)  return 8'hBC;
    if (r < 14) return 8'h1C;
    if (r < 17) return 8'h3C;
    if (r < 19) return 8'h7C;
    if (r < 22) return 8'hF7;
    k = 1'b0;
    return 8'($urandom);
  endfunction

  initial begin
    build_keystream();
    reset = 1'b1; gen = 3'd1; pipewidth = 6'd8; turnOff = 1'b0;
    RxData = '0; RxDataK = '0; RxValid = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_DataOut", DataOut, 32'h0);
    chk("rst_DataKOut", {28'h0, DataKOut}, 32'h0);
    chk("rst_DataValidOut", {31'h0, DataValidOut}, 32'h0);
    chk("rst_locked", {31'h0, locked}, 32'h0);
    reset = 1'b0;
    model_reset();

    // Byte-wide: SKP right after COM keeps the TS window closed, so keystream bytes descramble to 00.
    cyc(32'hBC, 4'h1, 1);
    cyc(32'h1C, 4'h1, 1);
    foreach (ks[p]) begin
      if (p >= 8) break;
      cyc({24'h0, ks[p]}, 4'h0, 1);
    end
    cyc(32'h0, 4'h0, 0);
    chk("hold_DataOut", DataOut, m_last);

    // SKPs do not advance the LFSR.
    cyc(32'hBC, 4'h1, 1);
    repeat (3) cyc(32'h1C, 4'h1, 1);
    cyc(32'hFF, 4'h0, 1);
    cyc(32'h17, 4'h0, 1);

    // TS1 body after COM is bypassed for 15 symbols.
    cyc(32'hBC, 4'h1, 1);
    repeat (15) cyc(32'h4A, 4'h0, 1);
    cyc(32'hFF, 4'h0, 1);

    // 4-symbol words.
    cyc(32'h0, 4'h0, 0);
    pipewidth = 6'd32;
    cyc(32'h17FF1CBC, 4'h3, 1);
    cyc(32'hE7B214C0, 4'h0, 1);
    cyc(32'h4A4A4ABC, 4'h1, 1);
    pipewidth = 6'd16;
    cyc(32'h0, 4'h0, 0);
    cyc(32'hDEAD7CBC, 4'h3, 1);

    // XOR disabled while framing continues.
    pipewidth = 6'd8; turnOff = 1'b1;
    cyc(32'hBC, 4'h1, 1);
    cyc(32'h1C, 4'h1, 1);
    cyc(32'hFF, 4'h0, 1);
    cyc(32'h17, 4'h0, 1);
    turnOff = 1'b0;
    do_reset();
    cyc(32'hFF, 4'h0, 1);

    // Generation change mid-stream drops lock; gen 3 passes data through.
    cyc(32'hBC, 4'h1, 1);
    cyc(32'h1C, 4'h1, 1);
    gen = 3'd3;
    cyc(32'h55, 4'h0, 1);
    cyc(32'hBC, 4'h1, 1);
    cyc(32'h1C, 4'h1, 1);
    cyc(32'hFF, 4'h0, 1);
    gen = 3'd1;
    cyc(32'hBC, 4'h1, 1);
    cyc(32'h1C, 4'h1, 1);
    cyc(32'hFF, 4'h0, 1);

    // Reset mid-stream clears everything on the next edge.
    do_reset();
    chk("midrst_DataOut", DataOut, 32'h0);
    chk("midrst_DataKOut", {28'h0, DataKOut}, 32'h0);
    chk("midrst_DataValidOut", {31'h0, DataValidOut}, 32'h0);
    chk("midrst_locked", {31'h0, locked}, 32'h0);

    for (int c = 0; c < 1500; c++) begin
      bit          v = ($urandom_range(0, 9) != 0);
      logic [31:0] d = '0;
      logic [3:0]  k = '0;
      if (!v && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: pipewidth = 6'd8;
          1: pipewidth = 6'd16;
          2: pipewidth = 6'd32;
          default: pipewidth = 6'd5;
        endcase
      end
      if ($urandom_range(0, 149) == 0) gen = 3'($urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) turnOff = ~turnOff;
      for (int i = 0; i < 4; i++) begin
        bit kk;
        d[8*i +: 8] = rnd_sym(kk);
        k[i] = kk;
      end
      cyc(d, k, v);
    end

    RxValid = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
